// File: rtl/filt_unpack.sv
// Frame-to-word deserializer: buffers DEPTH wide filter frames and streams them out word 0 first.
// States: IDLE = FIFO empty, no word offered | STREAM = head frame slice idx offered on word_*.
module filt_unpack #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 6,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_valid,
  input  logic [WIDTH*NWORDS-1:0] frame_data,
  input  logic [1:0]              frame_err,
  output logic                    frame_ready,
  output logic [WIDTH-1:0]        word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    word_last,
  output logic [1:0]              word_err,
  output logic [7:0]              drop_cnt
);

  localparam int FW = WIDTH * NWORDS;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [PW-1:0] P_ONE    = PW'(1);
  localparam logic [IW-1:0] I_ONE    = IW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                          state_q, state_d;
  logic [FW-1:0]                   data_mem [DEPTH];
  logic [1:0]                      err_mem  [DEPTH];
  logic [PW-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                   count_q, count_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [7:0]                      drop_q, drop_d;
  logic                            push, pop, hs, is_last;
  logic [NWORDS-1:0][WIDTH-1:0]    head_words;

  assign frame_ready = (count_q != FULL);
  assign push        = frame_valid && frame_ready;
  assign is_last     = (idx_q == LAST_IDX);
  assign hs          = (state_q == STREAM) && word_ready;
  assign pop         = hs && is_last;
  assign head_words  = data_mem[rd_ptr_q];
  assign drop_cnt    = drop_q;

  // Frame storage carries no reset; outputs are gated by the FSM while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= frame_data;
      err_mem[wr_ptr_q]  <= frame_err;
    end
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    drop_d   = drop_q;
    case ({push, pop})
      2'b10:   count_d = count_q + C_ONE;
      2'b01:   count_d = count_q - C_ONE;
      default: count_d = count_q;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + P_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + P_ONE;
    if (hs)   idx_d = is_last ? '0 : idx_q + I_ONE;
    if (frame_valid && !frame_ready && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_comb begin
    state_d    = state_q;
    word_valid = 1'b0;
    word_last  = 1'b0;
    word_data  = '0;
    word_err   = '0;
    case (state_q)
      IDLE: begin
        if (push) state_d = STREAM;
      end
      STREAM: begin
        word_valid = 1'b1;
        word_data  = head_words[idx_q];
        word_last  = is_last;
        word_err   = err_mem[rd_ptr_q];
        if (count_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_filt_unpack.sv
// Bench for filt_unpack: directed scenarios plus random traffic against a frame-queue model.
module tb_filt_unpack;
  localparam int NW    = 6;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_valid = 1'b0;
  logic [95:0] frame_data = '0;
  logic [1:0]  frame_err = '0;
  logic        frame_ready;
  logic [15:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        word_last;
  logic [1:0]  word_err;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [95:0] mq_d[$];
  logic [1:0]  mq_e[$];
  int          m_idx = 0;
  int          m_drop = 0;

  filt_unpack #(.WIDTH(16), .NWORDS(NW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .frame_valid(frame_valid), .frame_data(frame_data), .frame_err(frame_err),
    .frame_ready(frame_ready),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .word_last(word_last), .word_err(word_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    mq_d.delete();
    mq_e.delete();
    m_idx  = 0;
    m_drop = 0;
  endtask

  // Frame-level view: a queue of whole frames, a word position in the head, a drop tally.
  task automatic model_step();
    bit was_full, took;
    if (!rst) return;
    was_full = (mq_d.size() == DEPTH);
    took     = (mq_d.size() != 0) && word_ready;
    if (took) begin
      if (m_idx == NW - 1) begin
        void'(mq_d.pop_front());
        void'(mq_e.pop_front());
        m_idx = 0;
      end else m_idx++;
    end
    if (frame_valid) begin
      if (!was_full) begin
        mq_d.push_back(frame_data);
        mq_e.push_back(frame_err);
      end else if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic push_frame(input logic [95:0] d, input logic [1:0] e);
    frame_valid = 1'b1;
    frame_data  = d;
    frame_err   = e;
    tick();
    frame_valid = 1'b0;
  endtask

  function automatic logic [95:0] mk_frame(input logic [15:0] base);
    logic [95:0] f;
    for (int i = 0; i < NW; i++) f[i*16 +: 16] = base + 16'(i);
    return f;
  endfunction

  task automatic apply_reset();
    rst = 1'b0;
    frame_valid = 1'b0;
    word_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", word_valid); end
    n_cmp++; if (frame_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", frame_ready); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    n_cmp++; if ({word_data, word_last, word_err} !== 19'd0) begin n_err++;
      $display("FAIL reset_outs got data=%h last=%b err=%b want zeros", word_data, word_last, word_err); end
  endtask

  task automatic test_single();
    word_ready = 1'b1;
    push_frame(96'h0006_0005_0004_0003_0002_0001, 2'b00);
    for (int i = 0; i < NW; i++) begin
      n_cmp++; if (word_valid !== 1'b1 || word_data !== 16'(i + 1)) begin n_err++;
        $display("FAIL single_word%0d got v=%b d=%h want v=1 d=%h", i, word_valid, word_data, 16'(i + 1)); end
      n_cmp++; if (word_last !== (i == NW - 1)) begin n_err++;
        $display("FAIL single_last%0d got %b want %b", i, word_last, (i == NW - 1)); end
      tick();
    end
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL single_end got v=%b want 0", word_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    word_ready = 1'b1;
    push_frame(mk_frame(16'h0A01), 2'b00);
    for (int i = 0; i < 2 * NW; i++) begin
      exp = (i < NW) ? 16'(16'h0A01 + i) : 16'(16'h0B01 + i - NW);
      n_cmp++; if (word_valid !== 1'b1 || word_data !== exp || word_last !== (i % NW == NW - 1)) begin n_err++;
        $display("FAIL b2b_word%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", i, word_valid, word_data, word_last,
                 exp, (i % NW == NW - 1)); end
      if (i == NW - 1) push_frame(mk_frame(16'h0B01), 2'b00);
      else tick();
    end
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got v=%b want 0", word_valid); end
  endtask

  task automatic test_backpressure();
    word_ready = 1'b1;
    push_frame(96'h0006_0005_0004_0003_0002_0001, 2'b01);
    tick();
    tick();
    word_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (word_valid !== 1'b1 || word_data !== 16'h0003 || word_err !== 2'b01) begin n_err++;
        $display("FAIL bp_hold%0d got v=%b d=%h e=%b want v=1 d=0003 e=01", i, word_valid, word_data, word_err); end
    end
    word_ready = 1'b1;
    for (int i = 2; i < NW; i++) begin
      n_cmp++; if (word_valid !== 1'b1 || word_data !== 16'(i + 1)) begin n_err++;
        $display("FAIL bp_resume%0d got v=%b d=%h want v=1 d=%h", i, word_valid, word_data, 16'(i + 1)); end
      tick();
    end
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL bp_end got v=%b want 0", word_valid); end
  endtask

  task automatic test_overflow();
    int got;
    logic [15:0] exp;
    apply_reset();
    push_frame(mk_frame(16'h1101), 2'b00);
    tick();
    push_frame(mk_frame(16'h2201), 2'b00);
    tick();
    n_cmp++; if (frame_ready !== 1'b0) begin n_err++; $display("FAIL ovf_ready got %b want 0", frame_ready); end
    push_frame(mk_frame(16'h3301), 2'b00);
    push_frame(mk_frame(16'h4401), 2'b00);
    n_cmp++; if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL ovf_drop got %0d want 2", drop_cnt); end
    word_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (word_valid) begin
        exp = (got < NW) ? 16'(16'h1101 + got) : 16'(16'h2201 + got - NW);
        n_cmp++; if (got >= 2 * NW || word_data !== exp) begin n_err++;
          $display("FAIL ovf_word%0d got d=%h want %h (only 12 words expected)", got, word_data, exp); end
        got++;
      end
      tick();
    end
    n_cmp++; if (got !== 2 * NW) begin n_err++; $display("FAIL ovf_count got %0d words want %0d", got, 2 * NW); end
    word_ready = 1'b0;
    push_frame(mk_frame(16'h5501), 2'b00);
    push_frame(mk_frame(16'h6601), 2'b00);
    frame_valid = 1'b1;
    repeat (300) tick();
    frame_valid = 1'b0;
    n_cmp++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL ovf_sat got %0d want 255", drop_cnt); end
    word_ready = 1'b1;
    repeat (2 * NW + 2) tick();
    n_cmp++; if (word_valid !== 1'b0 || drop_cnt !== 8'd255) begin n_err++;
      $display("FAIL ovf_drain got v=%b drop=%0d want v=0 drop=255", word_valid, drop_cnt); end
  endtask

  task automatic test_err_tag();
    word_ready = 1'b1;
    push_frame(mk_frame(16'h7701), 2'b10);
    for (int i = 0; i < 2 * NW; i++) begin
      n_cmp++; if (word_valid !== 1'b1 || word_err !== ((i < NW) ? 2'b10 : 2'b00)) begin n_err++;
        $display("FAIL err_word%0d got v=%b e=%b want v=1 e=%b", i, word_valid, word_err, (i < NW) ? 2'b10 : 2'b00); end
      if (i == NW - 1) push_frame(mk_frame(16'h8801), 2'b00);
      else tick();
    end
  endtask

  task automatic test_reset_midstream();
    word_ready = 1'b1;
    push_frame(mk_frame(16'h9901), 2'b11);
    tick();
    push_frame(mk_frame(16'hAA01), 2'b00);
    tick();
    n_cmp++; if (word_data !== 16'h9904 || frame_ready !== 1'b0) begin n_err++;
      $display("FAIL rstm_pre got d=%h rdy=%b want d=9904 rdy=0", word_data, frame_ready); end
    #2 rst = 1'b0;
    #1;
    model_clear();
    n_cmp++; if (word_valid !== 1'b0 || frame_ready !== 1'b1 || drop_cnt !== 8'd0) begin n_err++;
      $display("FAIL rstm_async got v=%b rdy=%b drop=%0d want v=0 rdy=1 drop=0", word_valid, frame_ready, drop_cnt); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL rstm_quiet%0d got v=%b want 0", i, word_valid); end
    end
  endtask

  task automatic test_random();
    logic [95:0] h;
    logic [15:0] ed;
    bit          ev;
    for (int c = 0; c < 3000; c++) begin
      ev = (mq_d.size() != 0);
      h  = ev ? mq_d[0] : '0;
      ed = ev ? h[m_idx*16 +: 16] : 16'h0;
      n_cmp++; if (word_valid !== ev || word_data !== ed || word_last !== (ev && m_idx == NW - 1) ||
                   word_err !== (ev ? mq_e[0] : 2'b00)) begin n_err++;
        $display("FAIL rand_word c=%0d got v=%b d=%h l=%b e=%b want v=%b d=%h l=%b e=%b", c, word_valid, word_data,
                 word_last, word_err, ev, ed, (ev && m_idx == NW - 1), ev ? mq_e[0] : 2'b00); end
      n_cmp++; if (frame_ready !== (mq_d.size() != DEPTH) || drop_cnt !== 8'(m_drop)) begin n_err++;
        $display("FAIL rand_ctl c=%0d got rdy=%b drop=%0d want rdy=%b drop=%0d", c, frame_ready, drop_cnt,
                 (mq_d.size() != DEPTH), m_drop); end
      frame_valid = ($urandom_range(0, 5) == 0);
      frame_data  = {$urandom(), $urandom(), $urandom()};
      frame_err   = 2'($urandom_range(0, 3));
      word_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    frame_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_err_tag();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
